// File: rtl/flash_bus_arbiter.sv
// Arbitrates the flash pins between an SPI master (0) and a QSPI master (1), with guard gaps and optional preemption.
// Grant, owner and abort are registered (1-cycle request-to-grant); the pin mux is combinational from the registered state.
module flash_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned MAX_HOLD     = 0
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic       iSPI_REQ,
    output logic       oSPI_GNT,
    input  logic       iSPI_SCK,
    input  logic       iSPI_CSn,
    input  logic       iSPI_MOSI,
    input  logic       iQSPI_REQ,
    output logic       oQSPI_GNT,
    input  logic       iQSPI_SCK,
    input  logic       iQSPI_CSn,
    input  logic [3:0] iQSPI_DOUT,
    input  logic [3:0] iQSPI_DOE,
    output logic       oFLASH_SCK,
    output logic       oFLASH_CSn,
    output logic [3:0] oFLASH_DOUT,
    output logic [3:0] oFLASH_DOE,
    output logic       oABORT,
    output logic [1:0] oOWNER
);
    typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1, S_GUARD} state_t;

    localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES);
    localparam logic [15:0] HOLD_MAX   = 16'(MAX_HOLD);

    state_t      state_q, state_d;
    logic [7:0]  guard_q, guard_d;
    logic [15:0] hold_q, hold_d;
    logic        last_q, last_d;
    logic        spi_gnt_q, spi_gnt_d, qspi_gnt_q, qspi_gnt_d;
    logic        abort_q, abort_d;
    logic [1:0]  owner_q, owner_d;

    logic own_req, own_csn, oth_req, preempt;
    logic arb, win0, win1;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q    <= S_IDLE;
            guard_q    <= 8'd0;
            hold_q     <= 16'd0;
            last_q     <= 1'b1;
            spi_gnt_q  <= 1'b0;
            qspi_gnt_q <= 1'b0;
            abort_q    <= 1'b0;
            owner_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            spi_gnt_q  <= spi_gnt_d;
            qspi_gnt_q <= qspi_gnt_d;
            abort_q    <= abort_d;
            owner_q    <= owner_d;
        end
    end

    // last_q names the previous owner, so a tie goes to the other master
    always_comb begin
        own_req = (state_q == S_OWN1) ? iQSPI_REQ : iSPI_REQ;
        own_csn = (state_q == S_OWN1) ? iQSPI_CSn : iSPI_CSn;
        oth_req = (state_q == S_OWN1) ? iSPI_REQ  : iQSPI_REQ;
        preempt = (HOLD_MAX != 16'd0) && (hold_q >= HOLD_MAX) && own_csn;
        win0    = iSPI_REQ  && (!iQSPI_REQ || last_q);
        win1    = iQSPI_REQ && (!iSPI_REQ  || !last_q);
    end

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        hold_d  = 16'd0;
        last_d  = last_q;
        arb     = 1'b0;
        unique case (state_q)
            S_IDLE: arb = 1'b1;
            S_OWN0, S_OWN1: begin
                if (!own_req || preempt) begin
                    state_d = S_GUARD;
                    guard_d = GUARD_LOAD;
                end else if ((HOLD_MAX != 16'd0) && oth_req) begin
                    hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
                end
            end
            S_GUARD: begin
                guard_d = guard_q - 8'd1;
                // the last guard cycle doubles as the idle evaluation
                if (guard_q <= 8'd1) begin
                    guard_d = 8'd0;
                    state_d = S_IDLE;
                    arb     = 1'b1;
                end
            end
        endcase
        if (arb) begin
            if (win0) begin
                state_d = S_OWN0;
                last_d  = 1'b0;
            end else if (win1) begin
                state_d = S_OWN1;
                last_d  = 1'b1;
            end
        end
    end

    always_comb begin
        spi_gnt_d  = (state_d == S_OWN0);
        qspi_gnt_d = (state_d == S_OWN1);
        owner_d    = {qspi_gnt_d, spi_gnt_d};
        abort_d    = ((state_q == S_OWN0) || (state_q == S_OWN1)) && !own_req && !own_csn;
    end

    always_comb begin
        oFLASH_SCK  = 1'b0;
        oFLASH_CSn  = 1'b1;
        oFLASH_DOUT = 4'b1100;
        oFLASH_DOE  = 4'b1100;
        unique case (state_q)
            S_OWN0: begin
                oFLASH_SCK  = iSPI_SCK;
                oFLASH_CSn  = iSPI_CSn;
                oFLASH_DOUT = {3'b110, iSPI_MOSI};
                oFLASH_DOE  = 4'b1101;
            end
            S_OWN1: begin
                oFLASH_SCK  = iQSPI_SCK;
                oFLASH_CSn  = iQSPI_CSn;
                oFLASH_DOUT = iQSPI_DOUT;
                oFLASH_DOE  = iQSPI_DOE;
            end
            S_IDLE, S_GUARD: ;
        endcase
    end

    assign oSPI_GNT  = spi_gnt_q;
    assign oQSPI_GNT = qspi_gnt_q;
    assign oABORT    = abort_q;
    assign oOWNER    = owner_q;
endmodule

// File: doc/flash_bus_arbiter.md
FLASH_BUS_ARBITER -- requirements
Module: flash_bus_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 4: cycles of forced idle (CS_n high, SCK low) between two ownerships; legal range 1..255.
REQ-002 Parameter MAX_HOLD, default 0: maximum owner cycles while the other master waits; 0 disables preemption.
REQ-003 iCLK  input  1  single clock for all logic.
REQ-004 iRESETn  input  1  reset, asynchronous, active-low.
REQ-005 iSPI_REQ / oSPI_GNT  input / output  1 / 1  bus request and grant, serial SPI master (master 0).
REQ-006 iSPI_SCK, iSPI_CSn, iSPI_MOSI  input  1 each  master 0 pin drive.
REQ-007 iQSPI_REQ / oQSPI_GNT  input / output  1 / 1  bus request and grant, QSPI master (master 1).
REQ-008 iQSPI_SCK, iQSPI_CSn  input  1 each  master 1 clock and chip select.
REQ-009 iQSPI_DOUT, iQSPI_DOE  input  4 each  master 1 data value and per-bit output enable.
REQ-010 oFLASH_SCK, oFLASH_CSn  output  1 each  to flash pins.
REQ-011 oFLASH_DOUT, oFLASH_DOE  output  4 each  pin data and enable; DQ0=MOSI, DQ1=MISO, DQ2=WP, DQ3=HOLD.
REQ-012 oABORT  output  1  one-cycle pulse on forced ownership loss.
REQ-013 oOWNER  output  2  00 idle/guard, 01 master 0, 10 master 1.

Function
REQ-014 The FSM SHALL have states IDLE, OWN0, OWN1 and GUARD, with all state, grants, oOWNER and oABORT registered.
REQ-015 IDLE pins SHALL be: SCK=0, CSn=1, DOUT=4'b1100, DOE=4'b1100 (WP/HOLD held high, DQ0/DQ1 released).
REQ-016 In IDLE with exactly one request, the FSM SHALL move to that OWNx next cycle and assert its GNT in the same cycle oOWNER changes (1-cycle latency).
REQ-017 For simultaneous requests, the FSM SHALL grant the master that did not own last; the post-reset winner is master 0.
REQ-018 In OWN0, pins SHALL be: SCK=iSPI_SCK, CSn=iSPI_CSn, DOUT={1,1,0,iSPI_MOSI}, DOE=4'b1101.
REQ-019 In OWN1, pins SHALL pass through iQSPI_SCK, iQSPI_CSn, iQSPI_DOUT and iQSPI_DOE unmodified.
REQ-020 Pin muxing SHALL be combinational from the registered state: no added latency on the master-to-pin path and no glitch at state change.
REQ-021 When the owner drops REQ while its CSn=1, the FSM SHALL enter GUARD, deassert GNT and load the guard counter with GUARD_CYCLES.
REQ-022 When the owner drops REQ while its CSn=0, the FSM SHALL do the same and also pulse oABORT for one cycle; the pins take IDLE values in that same cycle.
REQ-023 GUARD SHALL drive IDLE pin values, decrement once per cycle, and exit on reaching 0 to IDLE evaluation: a pending request gets its grant on the following cycle, and requests are ignored during GUARD.
REQ-024 With MAX_HOLD!=0, the hold counter SHALL count owner cycles while the other REQ=1 (and reset otherwise).
REQ-025 At hold count >= MAX_HOLD, preemption SHALL wait for owner CSn=1, then enter GUARD (oABORT=0) with the other master next in priority.
REQ-026 The counters SHALL be 8-bit (guard) and 16-bit (hold), with the hold counter saturating at 16'hFFFF rather than wrapping.
REQ-027 GNT to both masters SHALL never be asserted simultaneously, including for a single cycle.

Reset
REQ-028 On iRESETn low, asynchronously: state=IDLE, grants=0, oOWNER=00, oABORT=0, counters=0, pins at IDLE values, last-owner=master 1.
REQ-029 Reset mid-transfer SHALL force CSn high immediately, and no ownership SHALL survive the deassertion of reset.

Verification
REQ-030 Reset release, iSPI_REQ=1 at cycle 0 -> oSPI_GNT=1 and oOWNER=01 at cycle 1; pins follow the SPI master, DOE=1101.
REQ-031 Both REQ rise in the same cycle after reset -> master 0 granted; master 0 drops REQ with CSn=1 -> 4 guard cycles at CSn=1, then oQSPI_GNT=1.
REQ-032 Master 1 owning with CSn=0 drops REQ -> oABORT=1 for exactly one cycle and oFLASH_CSn=1 that cycle; GUARD follows.
REQ-033 MAX_HOLD=8, master 0 holds with CSn=0 and master 1 waiting -> no preemption until CSn=1; then GUARD and grant to master 1, with oABORT never set.
REQ-034 iRESETn asserted while in OWN1 with DOE=1111 -> same-cycle pins CSn=1 and DOE=1100, with both GNT=0.
REQ-035 A random-request soak of 10^5 cycles SHALL include assertions checking REQ-027, the CSn=1 guard length and the IDLE pin values.
